// File: rtl/complete_arbiter_if.sv
// Bundle between the functional-unit array and the completion arbiter:
// per-FU finished results in, per-lane CDB/ROB-complete broadcasts out.
interface complete_arbiter_if #(
  parameter int NUM_FU = 8,
  parameter int LANES  = 3,
  parameter int PR_W   = 6,
  parameter int ROB_W  = 5,
  parameter int XLEN   = 32
);

  logic [NUM_FU-1:0]            fu_valid;
  logic [NUM_FU-1:0][PR_W-1:0]  fu_dest_pr;
  logic [NUM_FU-1:0][XLEN-1:0]  fu_value;
  logic [NUM_FU-1:0][ROB_W-1:0] fu_rob;
  logic [NUM_FU-1:0]            fu_ready;

  logic [LANES-1:0]             cdb_valid;
  logic [LANES-1:0][PR_W-1:0]   cdb_tag;
  logic [LANES-1:0][XLEN-1:0]   cdb_value;
  logic [LANES-1:0][ROB_W-1:0]  complete_rob;

  // Arbiter side: consumes FU results, produces lane broadcasts.
  modport slave (
    input  fu_valid, fu_dest_pr, fu_value, fu_rob,
    output fu_ready, cdb_valid, cdb_tag, cdb_value, complete_rob
  );

  // FU-array / write-back side.
  modport master (
    output fu_valid, fu_dest_pr, fu_value, fu_rob,
    input  fu_ready, cdb_valid, cdb_tag, cdb_value, complete_rob
  );

endinterface

// File: rtl/complete_arbiter.sv
// Completion arbiter: one holding slot per functional unit, up to LANES
// results granted per cycle onto the CDB with a rotating-priority scan.
// Losers stay parked in their slot and back-pressure their FU.
module complete_arbiter #(
  parameter int NUM_FU = 8,
  parameter int LANES  = 3,
  parameter int PR_W   = 6,
  parameter int ROB_W  = 5,
  parameter int XLEN   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  complete_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // Slot state
  logic [NUM_FU-1:0]            slot_valid;
  logic [NUM_FU-1:0][PR_W-1:0]  slot_tag;
  logic [NUM_FU-1:0][XLEN-1:0]  slot_value;
  logic [NUM_FU-1:0][ROB_W-1:0] slot_rob;
  logic [PTR_W-1:0]             ptr;

  // Arbitration results
  logic [NUM_FU-1:0]             grant;
  logic [LANES-1:0]              lane_hit;
  logic [LANES-1:0][PTR_W-1:0]   lane_sel;
  logic [PTR_W-1:0]              last_idx;
  logic [PTR_W-1:0]              ptr_next;
  logic [NUM_FU-1:0]             fu_ready_int;
  logic [NUM_FU-1:0]             slot_load;

  // Rotating scan from ptr: the first LANES occupied slots win, packed into lanes from 0.
  always_comb begin
    int cnt;
    int idx;
    // NOTE: combinational logic uses blocking '=' and assigns a default to every
    // output first, so no path leaves a value unassigned and no latch is inferred.
    grant    = '0;
    lane_hit = '0;
    lane_sel = '0;
    last_idx = '0;
    cnt      = 0;
    idx      = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      idx = int'(ptr) + j;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (slot_valid[idx] && (cnt < LANES)) begin
        grant[idx]    = 1'b1;
        lane_hit[cnt] = 1'b1;
        lane_sel[cnt] = PTR_W'(idx);
        last_idx      = PTR_W'(idx);
        cnt           = cnt + 1;
      end
    end
  end

  // Next pointer sits just past the last winner, wrapping at NUM_FU.
  always_comb begin
    ptr_next = (int'(last_idx) == NUM_FU - 1) ? '0 : last_idx + 1'b1;
  end

  // A slot accepts when empty or draining this cycle; squash blocks all intake.
  always_comb begin
    fu_ready_int = squash ? '0 : (~slot_valid | grant);
    slot_load    = bus.fu_valid & fu_ready_int;
  end

  assign bus.fu_ready = fu_ready_int;

  // Lane outputs come only from registered slot state; idle or squashed lanes read as zero.
  always_comb begin
    bus.cdb_valid    = '0;
    bus.cdb_tag      = '0;
    bus.cdb_value    = '0;
    bus.complete_rob = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_hit[k] && !squash) begin
        bus.cdb_valid[k]    = 1'b1;
        bus.cdb_tag[k]      = slot_tag[lane_sel[k]];
        bus.cdb_value[k]    = slot_value[lane_sel[k]];
        bus.complete_rob[k] = slot_rob[lane_sel[k]];
      end
    end
  end

  // Occupancy: load beats drain beats hold; squash empties every slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
    end else if (squash) begin
      slot_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (slot_load[i])  slot_valid[i] <= 1'b1;
        else if (grant[i]) slot_valid[i] <= 1'b0;
      end
    end
  end

  // Slot payload captured alongside the valid bit.
  // NOTE: payload is left unreset on purpose; it is only ever observed through
  // slot_valid, which is reset, so clearing the storage would buy nothing.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (slot_load[i]) begin
        slot_tag[i]   <= bus.fu_dest_pr[i];
        slot_value[i] <= bus.fu_value[i];
        slot_rob[i]   <= bus.fu_rob[i];
      end
    end
  end

  // Round-robin pointer advances only when something was granted and not squashed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (!squash && (|grant)) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed bench for complete_arbiter: each task drives one scenario and
// compares lane outputs, back-pressure and the rotating pointer against
// hand-derived values.
module tb_complete_arbiter;

  logic clock;
  logic reset;
  logic squash;
  int   tests;
  int   fails;

  complete_arbiter_if #(.NUM_FU(8), .LANES(3), .PR_W(6), .ROB_W(5), .XLEN(32)) bus ();

  complete_arbiter #(.NUM_FU(8), .LANES(3), .PR_W(6), .ROB_W(5), .XLEN(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Protocol: an FU may only present a result while its slot is ready.
  always @(posedge clock) begin
    if (!reset) begin
      assert ((bus.fu_valid & ~bus.fu_ready) == 8'h00)
        else $error("protocol violation fu_valid=%b fu_ready=%b", bus.fu_valid, bus.fu_ready);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fu_valid   = '0;
    bus.fu_dest_pr = '0;
    bus.fu_value   = '0;
    bus.fu_rob     = '0;
  endtask

  task automatic drive(input int fu, input logic [5:0] tag, input logic [31:0] val,
                       input logic [4:0] rob);
    bus.fu_valid[fu]   = 1'b1;
    bus.fu_dest_pr[fu] = tag;
    bus.fu_value[fu]   = val;
    bus.fu_rob[fu]     = rob;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    squash = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (bus.cdb_valid !== 3'b000 || bus.cdb_tag !== '0 || bus.complete_rob !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b tag=%h rob=%h required all zero",
               bus.cdb_valid, bus.cdb_tag, bus.complete_rob);
    end
    tests++;
    if (bus.fu_ready !== 8'hFF) begin
      fails++;
      $display("FAIL reset_ready: got %b required 11111111", bus.fu_ready);
    end
    tests++;
    if (dut.ptr !== 3'd0) begin
      fails++;
      $display("FAIL reset_ptr: got %0d required 0", dut.ptr);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    drive(2, 6'd5, 32'hDEAD, 5'd3);
    tick();
    clear_inputs();
    tests++;
    if (bus.cdb_valid !== 3'b001 || bus.cdb_tag !== {6'd0, 6'd0, 6'd5}
        || bus.cdb_value !== {32'd0, 32'd0, 32'hDEAD} || bus.complete_rob !== {5'd0, 5'd0, 5'd3}) begin
      fails++;
      $display("FAIL single_lane: valid=%b tag=%h value=%h rob=%h required 001/5/DEAD/3",
               bus.cdb_valid, bus.cdb_tag, bus.cdb_value, bus.complete_rob);
    end
    tick();
    tests++;
    if (dut.ptr !== 3'd3) begin
      fails++;
      $display("FAIL single_ptr: got %0d required 3", dut.ptr);
    end
    tests++;
    if (bus.cdb_valid !== 3'b000 || bus.fu_ready !== 8'hFF) begin
      fails++;
      $display("FAIL single_free: valid=%b ready=%b required 000/11111111",
               bus.cdb_valid, bus.fu_ready);
    end
  endtask

  task automatic test_overflow();
    pulse_reset();
    for (int i = 0; i < 8; i++) drive(i, 6'(i + 1), 32'h100 + 32'(i), 5'(i));
    tick();
    clear_inputs();
    tests++;
    if (bus.cdb_valid !== 3'b111 || bus.cdb_tag !== {6'd3, 6'd2, 6'd1}
        || bus.complete_rob !== {5'd2, 5'd1, 5'd0}) begin
      fails++;
      $display("FAIL overflow_c1: valid=%b tag=%h rob=%h required 111/slots 0,1,2",
               bus.cdb_valid, bus.cdb_tag, bus.complete_rob);
    end
    tests++;
    if (bus.fu_ready !== 8'b00000111) begin
      fails++;
      $display("FAIL overflow_ready1: got %b required 00000111", bus.fu_ready);
    end
    tick();
    tests++;
    if (dut.ptr !== 3'd3 || bus.cdb_tag !== {6'd6, 6'd5, 6'd4}
        || bus.cdb_value !== {32'h105, 32'h104, 32'h103}) begin
      fails++;
      $display("FAIL overflow_c2: ptr=%0d tag=%h value=%h required 3/slots 3,4,5",
               dut.ptr, bus.cdb_tag, bus.cdb_value);
    end
    tests++;
    if (bus.fu_ready !== 8'b00111111) begin
      fails++;
      $display("FAIL overflow_ready2: got %b required 00111111", bus.fu_ready);
    end
    tick();
    tests++;
    if (dut.ptr !== 3'd6 || bus.cdb_valid !== 3'b011 || bus.cdb_tag !== {6'd0, 6'd8, 6'd7}) begin
      fails++;
      $display("FAIL overflow_c3: ptr=%0d valid=%b tag=%h required 6/011/slots 6,7",
               dut.ptr, bus.cdb_valid, bus.cdb_tag);
    end
    tick();
    tests++;
    if (dut.ptr !== 3'd0 || bus.cdb_valid !== 3'b000) begin
      fails++;
      $display("FAIL overflow_drain: ptr=%0d valid=%b required 0/000", dut.ptr, bus.cdb_valid);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] want;
    pulse_reset();
    want = 8'h0F;
    for (int i = 0; i < 8; i++) if (want[i] || i == 7) drive(i, 6'(i + 1), 32'(i), 5'(i));
    tick();
    clear_inputs();
    tests++;
    if (bus.cdb_tag !== {6'd3, 6'd2, 6'd1}) begin
      fails++;
      $display("FAIL fair_c1: tag=%h required FU2,FU1,FU0", bus.cdb_tag);
    end
    for (int i = 0; i < 8; i++) if (want[i] && bus.fu_ready[i]) drive(i, 6'(i + 1), 32'(i), 5'(i));
    tests++;
    if (bus.fu_valid !== 8'h07) begin
      fails++;
      $display("FAIL fair_ready: accepted %b required 00000111", bus.fu_valid);
    end
    tick();
    clear_inputs();
    tests++;
    if (dut.ptr !== 3'd3 || bus.cdb_tag !== {6'd1, 6'd8, 6'd4}) begin
      fails++;
      $display("FAIL fair_wrap: ptr=%0d tag=%h required 3/FU0,FU7,FU3", dut.ptr, bus.cdb_tag);
    end
    tick();
    tests++;
    if (dut.ptr !== 3'd1 || bus.cdb_valid !== 3'b011 || bus.cdb_tag !== {6'd0, 6'd3, 6'd2}) begin
      fails++;
      $display("FAIL fair_c3: ptr=%0d valid=%b tag=%h required 1/011/FU1,FU2",
               dut.ptr, bus.cdb_valid, bus.cdb_tag);
    end
    tick();
    tests++;
    if (dut.ptr !== 3'd3 || bus.cdb_valid !== 3'b000 || bus.fu_ready !== 8'hFF) begin
      fails++;
      $display("FAIL fair_drain: ptr=%0d valid=%b ready=%b required 3/000/11111111",
               dut.ptr, bus.cdb_valid, bus.fu_ready);
    end
  endtask

  task automatic test_back_to_back();
    drive(4, 6'd7, 32'd1, 5'd1);
    for (int v = 1; v <= 3; v++) begin
      tick();
      clear_inputs();
      tests++;
      if (bus.cdb_valid !== 3'b001 || bus.cdb_value[0] !== 32'(v) || bus.fu_ready[4] !== 1'b1) begin
        fails++;
        $display("FAIL b2b_%0d: valid=%b value=%0d ready4=%b required 001/%0d/1",
                 v, bus.cdb_valid, bus.cdb_value[0], bus.fu_ready[4], v);
      end
      if (v < 3) drive(4, 6'd7, 32'(v + 1), 5'(v + 1));
    end
    tick();
    tests++;
    if (bus.cdb_valid !== 3'b000 || dut.ptr !== 3'd5) begin
      fails++;
      $display("FAIL b2b_end: valid=%b ptr=%0d required 000/5", bus.cdb_valid, dut.ptr);
    end
  endtask

  task automatic test_no_writeback();
    drive(6, 6'd0, 32'h55, 5'd9);
    tick();
    clear_inputs();
    tests++;
    if (bus.cdb_valid !== 3'b001 || bus.cdb_tag !== '0 || bus.complete_rob !== {5'd0, 5'd0, 5'd9}) begin
      fails++;
      $display("FAIL nowb: valid=%b tag=%h rob=%h required 001/0/9",
               bus.cdb_valid, bus.cdb_tag, bus.complete_rob);
    end
    tick();
    tests++;
    if (dut.ptr !== 3'd7) begin
      fails++;
      $display("FAIL nowb_ptr: got %0d required 7", dut.ptr);
    end
  endtask

  task automatic test_squash();
    for (int i = 0; i < 5; i++) drive(i, 6'(i + 1), 32'(i), 5'(i));
    tick();
    clear_inputs();
    squash = 1'b1;
    #1;
    tests++;
    if (bus.cdb_valid !== 3'b000 || bus.fu_ready !== 8'h00) begin
      fails++;
      $display("FAIL squash_cycle: valid=%b ready=%b required 000/00000000",
               bus.cdb_valid, bus.fu_ready);
    end
    tick();
    squash = 1'b0;
    #1;
    tests++;
    if (bus.cdb_valid !== 3'b000 || bus.fu_ready !== 8'hFF || dut.ptr !== 3'd7) begin
      fails++;
      $display("FAIL squash_after: valid=%b ready=%b ptr=%0d required 000/11111111/7",
               bus.cdb_valid, bus.fu_ready, dut.ptr);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) drive(i, 6'(i + 1), 32'(i), 5'(i));
    tick();
    clear_inputs();
    tests++;
    if (bus.cdb_valid !== 3'b111) begin
      fails++;
      $display("FAIL areset_pre: valid=%b required 111", bus.cdb_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (bus.cdb_valid !== 3'b000 || bus.cdb_tag !== '0 || bus.fu_ready !== 8'hFF || dut.ptr !== 3'd0) begin
      fails++;
      $display("FAIL areset_now: valid=%b tag=%h ready=%b ptr=%0d required 000/0/11111111/0",
               bus.cdb_valid, bus.cdb_tag, bus.fu_ready, dut.ptr);
    end
    #1;
    reset = 1'b0;
    tick();
    tests++;
    if (bus.cdb_valid !== 3'b000 || bus.fu_ready !== 8'hFF) begin
      fails++;
      $display("FAIL areset_post: valid=%b ready=%b required 000/11111111",
               bus.cdb_valid, bus.fu_ready);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_overflow();
    test_fairness();
    test_back_to_back();
    test_no_writeback();
    test_squash();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
